// File: rtl/winner_scanner.sv
// rtl/winner_scanner.sv - sequential N-candidate vote winner scanner with tie reporting
// Optional per-slot tie mask second pass enabled by defining WINNER_TIE_MASK_EN.
module winner_scanner #(
  parameter int NUM_CAND = 3,
  parameter int CAND_W = 4,
  parameter int VOTE_W = 4,
  localparam int TC_W = $clog2(NUM_CAND + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_CAND*CAND_W-1:0] candidate_numbers,
  input  logic [NUM_CAND*VOTE_W-1:0] vote_counts,
  output logic                       busy,
  output logic                       done,
  output logic [CAND_W-1:0]          winner_candidate,
  output logic [VOTE_W-1:0]          winner_vote_count,
  output logic                       tie,
  output logic [TC_W-1:0]            tie_count
`ifdef WINNER_TIE_MASK_EN
  ,
  output logic [NUM_CAND-1:0]        tie_mask
`endif
);

  localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_MASK,
    S_FINISH
  } state_t;

`ifdef WINNER_TIE_MASK_EN
  localparam state_t AFTER_SCAN = S_MASK;
`else
  localparam state_t AFTER_SCAN = S_FINISH;
`endif

  state_t state, state_n;

  logic [NUM_CAND*CAND_W-1:0] snap_cand;
  logic [NUM_CAND*VOTE_W-1:0] snap_votes;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           best_idx;
  logic [VOTE_W-1:0]          best_votes;
  logic [TC_W-1:0]            run_cnt;
  logic [VOTE_W-1:0]          cur_votes;
`ifdef WINNER_TIE_MASK_EN
  logic [NUM_CAND-1:0]        mask_acc;
`endif

  assign cur_votes = snap_votes[idx*VOTE_W +: VOTE_W];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = (NUM_CAND == 1) ? AFTER_SCAN : S_SCAN;
        end
      end
      S_SCAN: begin
        if (idx == LAST_IDX) begin
          state_n = AFTER_SCAN;
        end
      end
`ifdef WINNER_TIE_MASK_EN
      S_MASK: begin
        if (idx == LAST_IDX) begin
          state_n = S_FINISH;
        end
      end
`endif
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_cand         <= '0;
      snap_votes        <= '0;
      idx               <= '0;
      best_idx          <= '0;
      best_votes        <= '0;
      run_cnt           <= '0;
      done              <= 1'b0;
      winner_candidate  <= '0;
      winner_vote_count <= '0;
      tie               <= 1'b0;
      tie_count         <= '0;
`ifdef WINNER_TIE_MASK_EN
      mask_acc          <= '0;
      tie_mask          <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            snap_cand  <= candidate_numbers;
            snap_votes <= vote_counts;
            best_idx   <= '0;
            best_votes <= vote_counts[VOTE_W-1:0];
            run_cnt    <= TC_W'(1);
            idx        <= (NUM_CAND > 1) ? IDX_W'(1) : '0;
`ifdef WINNER_TIE_MASK_EN
            mask_acc   <= '0;
`endif
          end
        end
        S_SCAN: begin
          // Strict greater-than keeps the lowest slot index among equal maxima.
          if (cur_votes > best_votes) begin
            best_idx   <= idx;
            best_votes <= cur_votes;
            run_cnt    <= TC_W'(1);
          end else if (cur_votes == best_votes) begin
            run_cnt <= run_cnt + TC_W'(1);
          end
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
`ifdef WINNER_TIE_MASK_EN
        S_MASK: begin
          mask_acc[idx] <= (cur_votes == best_votes);
          idx           <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
`endif
        S_FINISH: begin
          winner_candidate  <= snap_cand[best_idx*CAND_W +: CAND_W];
          winner_vote_count <= best_votes;
          tie_count         <= run_cnt;
          tie               <= (run_cnt > TC_W'(1));
          done              <= 1'b1;
`ifdef WINNER_TIE_MASK_EN
          tie_mask          <= mask_acc;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_winner_scanner.sv
// tb/tb_winner_scanner.sv - table-driven bench for winner_scanner (N=3, N=8, N=1 instances)
// Honours WINNER_TIE_MASK_EN for tie_mask checks and doubled latency.
module tb_winner_scanner;

`ifdef WINNER_TIE_MASK_EN
  localparam int MF = 2;
`else
  localparam int MF = 1;
`endif
  localparam int LAT3 = 3 * MF;
  localparam int LAT8 = 8 * MF;
  localparam int LAT1 = 1 * MF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start3 = 1'b0, start8 = 1'b0, start1 = 1'b0;
  logic [11:0] cand3 = '0, votes3 = '0;
  logic [31:0] cand8 = '0;
  logic [63:0] votes8 = '0;
  logic [3:0]  cand1 = '0, votes1 = '0;

  logic busy3, done3, tie3, busy8, done8, tie8, busy1, done1, tie1;
  logic [3:0] win3, vc3, win8, win1, vc1, tc8;
  logic [7:0] vc8;
  logic [1:0] tc3;
  logic       tc1;
`ifdef WINNER_TIE_MASK_EN
  logic [2:0] mask3;
  logic [7:0] mask8;
  logic       mask1;
`endif

  winner_scanner #(.NUM_CAND(3), .CAND_W(4), .VOTE_W(4)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .candidate_numbers(cand3), .vote_counts(votes3),
    .busy(busy3), .done(done3), .winner_candidate(win3),
    .winner_vote_count(vc3), .tie(tie3), .tie_count(tc3)
`ifdef WINNER_TIE_MASK_EN
    , .tie_mask(mask3)
`endif
  );

  winner_scanner #(.NUM_CAND(8), .CAND_W(4), .VOTE_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .candidate_numbers(cand8), .vote_counts(votes8),
    .busy(busy8), .done(done8), .winner_candidate(win8),
    .winner_vote_count(vc8), .tie(tie8), .tie_count(tc8)
`ifdef WINNER_TIE_MASK_EN
    , .tie_mask(mask8)
`endif
  );

  winner_scanner #(.NUM_CAND(1), .CAND_W(4), .VOTE_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .candidate_numbers(cand1), .vote_counts(votes1),
    .busy(busy1), .done(done1), .winner_candidate(win1),
    .winner_vote_count(vc1), .tie(tie1), .tie_count(tc1)
`ifdef WINNER_TIE_MASK_EN
    , .tie_mask(mask1)
`endif
  );

  int checks = 0;
  int errors = 0;
  int n_done3 = 0;

  always @(posedge clk) begin
    if (done3) n_done3 <= n_done3 + 1;
  end

  typedef struct {
    logic [11:0] cand;
    logic [11:0] votes;
    logic        scramble;
    logic [3:0]  w;
    logic [3:0]  v;
    logic        tie;
    logic [1:0]  tc;
    logic [2:0]  mask;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  function automatic logic sel_done(input int sel);
    case (sel)
      0: return done3;
      1: return done8;
      default: return done1;
    endcase
  endfunction

  // Counts edges after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(input int sel, input int maxc, output int lat);
    lat = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel_done(sel)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run3(input int id, input vec_t v);
    int lat;
    @(negedge clk);
    cand3 = v.cand; votes3 = v.votes; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    if (v.scramble) begin
      cand3 = '1; votes3 = '1;
    end
    chk("busy_during", id, busy3, 1'b1);
    wait_done(0, LAT3 + 4, lat);
    chk("latency", id, lat, LAT3);
    chk("winner", id, win3, v.w);
    chk("votes", id, vc3, v.v);
    chk("tie", id, tie3, v.tie);
    chk("tie_count", id, tc3, v.tc);
`ifdef WINNER_TIE_MASK_EN
    chk("tie_mask", id, mask3, v.mask);
`endif
    chk("busy_at_done", id, busy3, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", id, done3, 1'b0);
  endtask

  initial begin
    int lat, n0;
    //        cand{s2,s1,s0}           votes{s2,s1,s0}         scr   w      v      tie   tc     mask
    vt[0] = '{{4'd2, 4'd1, 4'd0}, {4'd1, 4'd2, 4'd3}, 1'b0, 4'd0, 4'd3, 1'b0, 2'd1, 3'b001};
    vt[1] = '{{4'd2, 4'd1, 4'd0}, {4'd2, 4'd4, 4'd1}, 1'b1, 4'd1, 4'd4, 1'b0, 2'd1, 3'b010};
    vt[2] = '{{4'd2, 4'd1, 4'd0}, {4'd2, 4'd3, 4'd3}, 1'b0, 4'd0, 4'd3, 1'b1, 2'd2, 3'b011};
    vt[3] = '{{4'd7, 4'd9, 4'd5}, {4'd0, 4'd0, 4'd0}, 1'b0, 4'd5, 4'd0, 1'b1, 2'd3, 3'b111};
    vt[4] = '{{4'hA, 4'hB, 4'hC}, {4'd5, 4'd5, 4'd1}, 1'b0, 4'hB, 4'd5, 1'b1, 2'd2, 3'b110};
    vt[5] = '{{4'hA, 4'hB, 4'hC}, {4'd9, 4'd2, 4'd2}, 1'b1, 4'hA, 4'd9, 1'b0, 2'd1, 3'b100};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 0, busy3, 1'b0);
    chk("rst_done", 0, done3, 1'b0);
    chk("rst_outs", 0, {win3, vc3, tie3, tc3}, '0);

    for (int i = 0; i < 6; i++) run3(i, vt[i]);

    // Start held high while busy and during FINISH must not queue a second scan.
    @(negedge clk);
    cand3 = vt[3].cand; votes3 = vt[3].votes; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n0 = n_done3;
    @(negedge clk);
    start3 = 1'b1;
    repeat (LAT3 - 1) @(negedge clk);
    start3 = 1'b0;
    chk("ign_done", 10, done3, 1'b1);
    chk("ign_winner", 10, {win3, vc3, tie3, tc3}, {4'd5, 4'd0, 1'b1, 2'd3});
    repeat (2 * LAT3 + 4) @(negedge clk);
    chk("ign_one_done", 10, n_done3 - n0, 1);
    chk("ign_busy", 10, busy3, 1'b0);
    chk("hold_outs", 10, {win3, vc3, tie3, tc3}, {4'd5, 4'd0, 1'b1, 2'd3});

    // Reset one cycle into a scan aborts with no done pulse.
    @(negedge clk);
    cand3 = vt[1].cand; votes3 = vt[1].votes; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 11, busy3, 1'b0);
    chk("abort_done", 11, done3, 1'b0);
    chk("abort_outs", 11, {win3, vc3, tie3, tc3}, '0);
    reset = 1'b0;
    n0 = n_done3;
    repeat (LAT3 + 4) @(negedge clk);
    chk("abort_no_done", 11, n_done3 - n0, 0);
    chk("abort_idle", 11, busy3, 1'b0);
    run3(12, vt[4]);

    // NUM_CAND = 8, VOTE_W = 8: ascending votes with slot 7 saturated.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      cand8[i*4 +: 4] = 4'(i);
      votes8[i*8 +: 8] = (i == 7) ? 8'd255 : 8'(10 * i);
    end
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(1, LAT8 + 4, lat);
    chk("n8_latency", 20, lat, LAT8);
    chk("n8_outs", 20, {win8, vc8, tie8, tc8}, {4'd7, 8'd255, 1'b0, 4'd1});
`ifdef WINNER_TIE_MASK_EN
    chk("n8_mask", 20, mask8, 8'h80);
`endif

    // NUM_CAND = 1 degenerate case.
    @(negedge clk);
    cand1 = 4'd6; votes1 = 4'd3; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(2, LAT1 + 4, lat);
    chk("n1_latency", 30, lat, LAT1);
    chk("n1_outs", 30, {win1, vc1, tie1, tc1}, {4'd6, 4'd3, 1'b0, 1'b1});
`ifdef WINNER_TIE_MASK_EN
    chk("n1_mask", 30, mask1, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
